// File: rtl/alu_pkg.sv
// Shared types for the alu_mc execute unit: command encodings, FSM states,
// flag bit positions and the iterative mul/div op select (used under ALU_MULDIV_EN).
package alu_pkg;

  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_SUB  = 4'd1,
    CMD_AND  = 4'd2,
    CMD_OR   = 4'd3,
    CMD_NOR  = 4'd4,
    CMD_XOR  = 4'd5,
    CMD_SLL  = 4'd6,
    CMD_SRL  = 4'd7,
    CMD_SRA  = 4'd8,
    CMD_SLT  = 4'd9,
    CMD_SLTU = 4'd10,
    CMD_MUL  = 4'd11,
    CMD_DIVU = 4'd12,
    CMD_REMU = 4'd13
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  localparam int FLAGS_W       = 6;
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_NEGATIVE = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_DIV_ZERO = 4;
  localparam int FLAG_ILLEGAL  = 5;

  function automatic logic is_muldiv(input alu_cmd_e cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_DIVU) || (cmd == CMD_REMU);
  endfunction

  function automatic logic [FLAGS_W-1:0] pack_flags(input logic zero, input logic neg,
                                                    input logic carry, input logic ovf,
                                                    input logic div_zero, input logic illegal);
    logic [FLAGS_W-1:0] f;
    f = '0;
    f[FLAG_ZERO]     = zero;
    f[FLAG_NEGATIVE] = neg;
    f[FLAG_CARRY]    = carry;
    f[FLAG_OVERFLOW] = ovf;
    f[FLAG_DIV_ZERO] = div_zero;
    f[FLAG_ILLEGAL]  = illegal;
    return f;
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Radix-2 iterative unit: shift-add multiplier and restoring divider, one bit per cycle.
// Only compiled when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // acc: product accumulator / partial remainder; xr: multiplicand / dividend-quotient;
  // yr: multiplier / divisor
  logic             busy;
  logic [CW-1:0]    cnt;
  md_op_e           op_r;
  logic [WIDTH-1:0] acc, xr, yr;
  logic [WIDTH-1:0] acc_nx, xr_nx, yr_nx;
  logic [WIDTH:0]   rem_sh;
  logic             q_bit;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    acc_nx = acc;
    xr_nx  = xr;
    yr_nx  = yr;
    rem_sh = {acc, xr[WIDTH-1]};
    q_bit  = 1'b0;
    if (op_r == MD_MUL) begin
      acc_nx = acc + (yr[0] ? xr : '0);
      xr_nx  = xr << 1;
      yr_nx  = yr >> 1;
    end else begin
      q_bit  = (rem_sh >= {1'b0, yr});
      // The true partial remainder always fits in WIDTH bits, so the narrow subtract is exact.
      acc_nx = q_bit ? (rem_sh[WIDTH-1:0] - yr) : rem_sh[WIDTH-1:0];
      xr_nx  = {xr[WIDTH-2:0], q_bit};
    end
  end

  assign done     = busy && (cnt == CNT_LAST);
  assign result   = (op_r == MD_DIVU) ? xr_nx : acc_nx;
  assign div_zero = busy && (op_r != MD_MUL) && (yr == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_r <= MD_MUL;
      acc  <= '0;
      xr   <= '0;
      yr   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      op_r <= op;
      acc  <= '0;
      xr   <= a;
      yr   <= b;
    end else if (busy) begin
      acc <= acc_nx;
      xr  <= xr_nx;
      yr  <= yr_nx;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// Registered ready/valid execute unit: FSM, single-cycle datapath, flags and output register.
// Define ALU_MULDIV_EN to add iterative MUL/DIVU/REMU; otherwise those codes are illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         exe_cmd,
  input  logic [WIDTH-1:0]   val1,
  input  logic [WIDTH-1:0]   val2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic [FLAGS_W-1:0] flags
);

  alu_state_e         state;
  alu_cmd_e           cmd;
  logic               accept;
  logic [WIDTH:0]     sum_ext, dif_ext;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry, sc_ovf, sc_ill;
  logic [FLAGS_W-1:0] sc_flags;

  assign cmd      = alu_cmd_e'(exe_cmd);
  assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept   = in_valid && in_ready;

  assign sum_ext = {1'b0, val1} + {1'b0, val2};
  assign dif_ext = {1'b0, val1} - {1'b0, val2};
  assign shamt   = val2[SHAMT_W-1:0];

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    case (cmd)
      CMD_ADD: begin
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = sum_ext[WIDTH];
        sc_ovf   = (val1[WIDTH-1] == val2[WIDTH-1]) && (sc_res[WIDTH-1] != val1[WIDTH-1]);
      end
      CMD_SUB: begin
        sc_res   = dif_ext[WIDTH-1:0];
        sc_carry = ~dif_ext[WIDTH];  // carry means "no borrow"
        sc_ovf   = (val1[WIDTH-1] != val2[WIDTH-1]) && (sc_res[WIDTH-1] != val1[WIDTH-1]);
      end
      CMD_AND:  sc_res = val1 & val2;
      CMD_OR:   sc_res = val1 | val2;
      CMD_NOR:  sc_res = ~(val1 | val2);
      CMD_XOR:  sc_res = val1 ^ val2;
      CMD_SLL:  sc_res = val1 << shamt;
      CMD_SRL:  sc_res = val1 >> shamt;
      CMD_SRA:  sc_res = $signed(val1) >>> shamt;
      CMD_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(val1) < $signed(val2)};
      CMD_SLTU: sc_res = {{(WIDTH-1){1'b0}}, val1 < val2};
      default:  sc_ill = 1'b1;
    endcase
  end

  assign sc_flags = sc_ill ? pack_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)
                           : pack_flags(sc_res == '0, sc_res[WIDTH-1], sc_carry, sc_ovf,
                                        1'b0, 1'b0);

`ifdef ALU_MULDIV_EN
  logic             multi;
  md_op_e           md_op;
  logic             md_done, md_dz;
  logic [WIDTH-1:0] md_result;

  assign multi = is_muldiv(cmd);

  always_comb begin
    case (cmd)
      CMD_DIVU: md_op = MD_DIVU;
      CMD_REMU: md_op = MD_REMU;
      default:  md_op = MD_MUL;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && multi),
    .op       (md_op),
    .a        (val1),
    .b        (val2),
    .done     (md_done),
    .result   (md_result),
    .div_zero (md_dz)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (multi) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
            end else
`endif
            begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              alu_out   <= sc_res;
              flags     <= sc_flags;
            end
          end else if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MULDIV_EN
        ST_BUSY: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            alu_out   <= md_result;
            flags     <= pack_flags(md_result == '0, md_result[WIDTH-1], 1'b0, 1'b0,
                                    md_dz, 1'b0);
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases, backpressure, reset abort,
// then random ops against an arithmetic reference model. Follows ALU_MULDIV_EN if defined.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   exe_cmd;
  logic [W-1:0] val1, val2, alu_out;
  logic [5:0]   flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exe_cmd   (exe_cmd),
    .val1      (val1),
    .val2      (val2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: flags laid out as {illegal, div_zero, overflow, carry, negative, zero}.
  function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [5:0] fl, output int lat);
    longint      sa, sb, sr;
    logic [63:0] wide;
    logic        c, v, dz, ill, md_en;
    int          sh;
`ifdef ALU_MULDIV_EN
    md_en = 1'b1;
`else
    md_en = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    c = 0; v = 0; dz = 0; ill = 0; lat = 1; res = 0;
    case (cmd)
      CMD_ADD: begin
        wide = {32'b0, a} + {32'b0, b};
        res  = wide[31:0];
        c    = wide[32];
        sr   = sa + sb;
        v    = (sr != longint'($signed(res)));
      end
      CMD_SUB: begin
        res = a - b;
        c   = (a >= b);
        sr  = sa - sb;
        v   = (sr != longint'($signed(res)));
      end
      CMD_AND:  res = a & b;
      CMD_OR:   res = a | b;
      CMD_NOR:  res = ~(a | b);
      CMD_XOR:  res = a ^ b;
      CMD_SLL:  res = a << sh;
      CMD_SRL:  res = a >> sh;
      CMD_SRA:  res = a[31] ? ~((~a) >> sh) : (a >> sh);
      CMD_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      CMD_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      CMD_MUL, CMD_DIVU, CMD_REMU: begin
        if (!md_en) ill = 1;
        else begin
          lat = W + 1;
          if (cmd == CMD_MUL) begin
            wide = {32'b0, a} * {32'b0, b};
            res  = wide[31:0];
          end else if (b == 0) begin
            dz  = 1;
            res = (cmd == CMD_DIVU) ? 32'hFFFF_FFFF : a;
          end else begin
            res = (cmd == CMD_DIVU) ? a / b : a % b;
          end
        end
      end
      default: ill = 1;
    endcase
    if (ill) begin
      res = 0;
      fl  = 6'b100000;
    end else begin
      fl = {1'b0, dz, v, c, res[31], res == 0};
    end
  endfunction

  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] er;
    logic [5:0]  ef;
    int          el, n, lat;
    model(cmd, a, b, er, ef, el);
    @(negedge clk);
    exe_cmd = cmd; val1 = a; val2 = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    val1 = $urandom; val2 = $urandom; exe_cmd = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(el));
    check({tag, "_result"}, 64'(alu_out), 64'(er));
    check({tag, "_flags"}, 64'(flags), 64'(ef));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(($urandom_range(0, 40)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er, held;
    logic [5:0]  ef;
    int          el, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    exe_cmd = '0; val1 = '0; val2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_alu_out", 64'(alu_out), 64'(0));
    check("reset_flags", 64'(flags), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));

    run_op("add_ovf", CMD_ADD, 32'h7FFF_FFFF, 32'd1);
    run_op("sub_zero", CMD_SUB, 32'd5, 32'd5);
    run_op("sub_borrow", CMD_SUB, 32'd0, 32'd1);
    run_op("sra_31", CMD_SRA, 32'h8000_0000, 32'd31);
    run_op("srl_31", CMD_SRL, 32'h8000_0000, 32'd31);
    run_op("sll_mask", CMD_SLL, 32'd1, 32'd33);
    run_op("slt_neg", CMD_SLT, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu_big", CMD_SLTU, 32'hFFFF_FFFF, 32'd1);
    run_op("nor", CMD_NOR, 32'h0F0F_0000, 32'h0000_00F0);
    run_op("xor", CMD_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000);
    run_op("illegal_15", 4'd15, 32'd3, 32'd4);
    run_op("mul_wrap", CMD_MUL, 32'h0001_0000, 32'h0001_0000);
    run_op("divu_zero", CMD_DIVU, 32'd7, 32'd0);
    run_op("remu", CMD_REMU, 32'd100, 32'd7);
    run_op("remu_zero", CMD_REMU, 32'd1234, 32'd0);

    // Backpressure: drain to IDLE, then stall the consumer for five cycles.
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exe_cmd = CMD_ADD; val1 = 32'd10; val2 = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    model(CMD_ADD, 32'd10, 32'd20, er, ef, el);
    check("bp_first_valid", 64'(out_valid), 64'(1));
    check("bp_first_result", 64'(alu_out), 64'(er));
    held = er;
    exe_cmd = CMD_SUB; val1 = 32'd9; val2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      check("bp_hold_result", 64'(alu_out), 64'(held));
      check("bp_hold_valid", 64'(out_valid), 64'(1));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_rise", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model(CMD_SUB, 32'd9, 32'd4, er, ef, el);
    check("bp_next_valid", 64'(out_valid), 64'(1));
    check("bp_next_result", 64'(alu_out), 64'(er));

`ifdef ALU_MULDIV_EN
    // Reset during the 10th BUSY cycle of a DIVU abandons it.
    @(negedge clk);
    exe_cmd = CMD_DIVU; val1 = 32'd1000; val2 = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_valid", 64'(out_valid), 64'(0));
    check("abort_busy_in_ready", 64'(in_ready), 64'(0));
`else
    // Reset while a result is held under backpressure abandons it.
    @(negedge clk);
    out_ready = 1'b0;
    exe_cmd = CMD_ADD; val1 = 32'd2; val2 = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_done_valid", 64'(out_valid), 64'(1));
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_alu_out", 64'(alu_out), 64'(0));
    check("abort_flags", 64'(flags), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_never_presented", 64'(seen), 64'(0));
    run_op("post_reset_add", CMD_ADD, 32'd2, 32'd3);

    for (int i = 0; i < 60; i++) begin
      run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), pick_operand(),
             pick_operand());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
